// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;
  localparam int   DATA_W     = 64;
  localparam int   REG_ADDR_W = 5;
  localparam logic OP_LD      = 1'b1;
  localparam logic OP_SD      = 1'b0;

  typedef enum logic [1:0] {IDLE, REQ, WB, DONE} lsu_state_e;
endpackage

// File: rtl/lsu_addr_gen.sv
// rtl/lsu_addr_gen.sv - effective address (base + sext offset) and doubleword misalign flag
module lsu_addr_gen #(
  parameter int DATA_W = lsu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] base_i,
  input  logic [11:0]       offset_i,
  output logic [DATA_W-1:0] ea_o,
  output logic              misaligned_o
);
  assign ea_o         = base_i + {{(DATA_W-12){offset_i[11]}}, offset_i};
  assign misaligned_o = |ea_o[2:0];
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding ld/sd sequencer between register bank and memory
module load_store_unit #(
  parameter int DATA_W     = lsu_pkg::DATA_W,
  parameter int MEM_ADDR_W = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           is_load,
  input  logic [lsu_pkg::REG_ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0]              base,
  input  logic [DATA_W-1:0]              sdata,
  input  logic [11:0]                    offset,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [MEM_ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ack,
  output logic [lsu_pkg::REG_ADDR_W-1:0] rf_Rw,
  output logic                           rf_WE,
  output logic [DATA_W-1:0]              rf_dIN,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  import lsu_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT);

  lsu_state_e              state_q, state_d;
  logic                    is_load_q, is_load_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [MEM_ADDR_W-1:0]   ea_q, ea_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [DATA_W-1:0]       ea;
  logic                    misaligned;
  logic                    unused_ea_hi;

  lsu_addr_gen #(.DATA_W(DATA_W)) u_addr_gen (
    .base_i       (base),
    .offset_i     (offset),
    .ea_o         (ea),
    .misaligned_o (misaligned)
  );

  assign unused_ea_hi = ^ea[DATA_W-1:MEM_ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      ea_q      <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      ea_q      <= ea_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // data_q carries the store data on the way out and the load data on the way back
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    rd_d      = rd_q;
    data_d    = data_q;
    ea_d      = ea_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_load_d = is_load;
          rd_d      = rd;
          data_d    = (is_load == OP_LD) ? '0 : sdata;
          ea_d      = ea[MEM_ADDR_W-1:0];
          err_d     = misaligned;
          cnt_d     = '0;
          state_d   = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack) begin
          if (is_load_q == OP_LD) begin
            data_d  = mem_rdata;
            state_d = WB;
          end else begin
            state_d = DONE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_Rw     = '0;
    rf_WE     = 1'b0;
    rf_dIN    = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = (is_load_q == OP_SD);
        mem_addr  = ea_q;
        mem_wdata = data_q;
      end
      WB: begin
        rf_Rw  = rd_q;
        rf_dIN = data_q;
        rf_WE  = (rd_q != '0);
      end
      DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequences one load or store at a time between the register bank (Reg_Banco) and a handshaked data memory.
- Consumes the bank's read ports: doutB is the base address, doutA is the store data.
- Forms effective address = base + sign-extended 12-bit offset, then performs the memory access.
- Loads are written back through the bank's write port (Rw, WE_Reg, dIN).

Parameters:
- DATA_W, 64, register/memory data width
- MEM_ADDR_W, 16, memory address width (low bits of effective address)
- TIMEOUT, 16, max cycles a request waits for mem_ack before abort (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; accepted only in IDLE
- is_load  in  1  1 = ld, 0 = sd; sampled with start
- rd  in  5  load destination register; sampled with start
- base  in  DATA_W  base address, from Reg_Banco doutB
- sdata  in  DATA_W  store data, from Reg_Banco doutA
- offset  in  12  signed immediate
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  MEM_ADDR_W  byte address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge
- rf_Rw  out  5  to Reg_Banco Rw
- rf_WE  out  1  to Reg_Banco WE_Reg
- rf_dIN  out  DATA_W  to Reg_Banco dIN
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or timeout

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; internal latches and timeout counter 0. mem_req drops without waiting for a clock; an in-flight access is abandoned and no writeback occurs.
- States: IDLE, REQ, WB, DONE.
- IDLE:
  - On start, latch is_load, rd and sdata. Register ea = base + sext(offset), computed modulo 2^DATA_W.
  - Misaligned (ea[2:0] != 0): go to DONE with err=1; no mem_req.
  - Otherwise: go to REQ.
- start in any state but IDLE is ignored; no queueing.
- REQ:
  - mem_req=1; mem_addr = ea[MEM_ADDR_W-1:0]; mem_we = !is_load; mem_wdata = latched sdata (0 for loads). All held stable until ack.
  - The counter increments each REQ cycle.
  - mem_ack high: store goes to DONE; load captures mem_rdata and goes to WB.
  - Counter reaches TIMEOUT-1 without ack: go to DONE with err=1; mem_req drops the next cycle.
  - mem_ack outside REQ is ignored.
- WB (one cycle):
  - rf_Rw = rd; rf_dIN = captured data.
  - rf_WE = 1 unless rd == 0 (x0 stays 0 in the bank).
- DONE (one cycle): done=1 and err valid, then IDLE.
- rf_WE is asserted only in WB. rf_Rw and rf_dIN return to 0 outside WB.
- Latency, counting the start cycle as 0 with ack in the first REQ cycle:
  - store: REQ at cycle 1, done at cycle 2
  - load: WB at cycle 2, done at cycle 3; the bank register is updated at the rising edge ending cycle 2
  - misaligned: done at cycle 1
- Back-to-back operation: start is accepted again in the cycle after DONE.
- busy = (state != IDLE).

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE, REQ, WB, DONE)
  - DATA_W and REG_ADDR_W = 5 constants
  - OP_LD = 1 and OP_SD = 0
- Sub-module lsu_addr_gen (combinational): base + sext(offset), plus the misalign flag. Reused by the later pipeline.

Test Plan:
- Load: base=24, offset=0, is_load=1, rd=9; memory acks after 2 cycles with 50 -> mem_addr=24, mem_we=0; rf_WE one-cycle pulse with rf_Rw=9, rf_dIN=50; done, err=0; Reg_Banco doutA with Ra=9 reads 50.
- Store: base=40, offset=-8, sdata=15, is_load=0; ack in the first REQ cycle -> mem_addr=32, mem_we=1, mem_wdata=15 held until ack; done at cycle 2; rf_WE never asserted.
- Load to x0: rd=0, memory returns 0xDEAD -> WB occurs with rf_WE=0; done, err=0.
- Misaligned: base=3, offset=0 -> mem_req never asserted; done at cycle 1 with err=1.
- Timeout: TIMEOUT=16, mem_ack held low -> mem_req high for exactly 16 cycles, then done with err=1, no rf_WE.
- Reset mid-load: rst_n low while in REQ -> mem_req and busy go 0 asynchronously; no rf_WE; start after release is accepted normally.
